pipeline_ex_mdu: RTL and testbench

PIPELINE_EX_MDU -- requirements
Module: pipeline_ex_mdu

---
 rtl/pipeline_ex_mdu.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_ex_mdu.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ex_mdu.sv
// Execute stage with single-cycle ALU ops and optional iterative multiply/divide.
// Define EX_MDU_EN to build the MULU/DIVU unit; without it those codes report illegal.
module pipeline_ex_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LUI  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;

    logic             accept;
    logic             mdu_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_illegal;

    logic             out_valid_next;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] result_hi_next;
    logic             zero_next;
    logic             ovf_next;
    logic             illegal_next;

    assign sum  = srca + srcb;
    assign diff = srca - srcb;

    always_comb begin
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_AND: alu_result = srca & srcb;
            OP_OR:  alu_result = srca | srcb;
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            OP_LUI: alu_result = srcb << 16;
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef EX_MDU_EN
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] work_reg, work_next;
    logic [WIDTH-1:0]   opnd_reg;
    logic               is_div_reg;
    logic               mdu_done;
    logic [WIDTH-1:0]   work_hi, work_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;

    assign mdu_op   = (op == 4'b1000) || (op == 4'b1001);
    assign mdu_done = (state_reg == BUSY) && (count_reg == CW'(1));
    assign in_ready = reset && (state_reg == IDLE) && (!out_valid || out_ready) && !flush;

    // work_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign work_hi   = work_reg[2*WIDTH-1:WIDTH];
    assign work_lo   = work_reg[WIDTH-1:0];
    assign mul_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd_reg : {WIDTH{1'b0}})};
    assign div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, opnd_reg};

    always_comb begin
        work_next = {mul_sum, work_lo[WIDTH-1:1]};
        if (is_div_reg) begin
            if (!div_trial[WIDTH])
                work_next = {div_trial[WIDTH-1:0], work_lo[WIDTH-2:0], 1'b1};
            else
                work_next = work_reg << 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept && mdu_op) state_next = BUSY;
                BUSY:    if (count_reg == CW'(1)) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg  <= '0;
            work_reg   <= '0;
            opnd_reg   <= '0;
            is_div_reg <= 1'b0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (accept && mdu_op) begin
            count_reg  <= CW'(WIDTH);
            is_div_reg <= op[0];
            work_reg   <= {{WIDTH{1'b0}}, (op[0] ? srca : srcb)};
            opnd_reg   <= op[0] ? srcb : srca;
        end else if (state_reg == BUSY) begin
            work_reg  <= work_next;
            count_reg <= count_reg - CW'(1);
        end
    end
`else
    assign mdu_op   = 1'b0;
    assign in_ready = reset && (!out_valid || out_ready) && !flush;
`endif

    assign accept = in_valid && in_ready;

    // flush beats accept and completion; an accepted MDU op frees the output slot
    always_comb begin
        out_valid_next = out_valid;
        result_next    = result;
        result_hi_next = result_hi;
        zero_next      = zero;
        ovf_next       = ovf;
        illegal_next   = illegal;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept && !mdu_op) begin
            out_valid_next = 1'b1;
            result_next    = alu_result;
            result_hi_next = '0;
            zero_next      = (alu_result == '0);
            ovf_next       = alu_ovf;
            illegal_next   = alu_illegal;
        end else if (accept) begin
            out_valid_next = 1'b0;
`ifdef EX_MDU_EN
        end else if (mdu_done) begin
            out_valid_next = 1'b1;
            result_next    = work_next[WIDTH-1:0];
            result_hi_next = work_next[2*WIDTH-1:WIDTH];
            zero_next      = (work_next[WIDTH-1:0] == '0);
            ovf_next       = 1'b0;
            illegal_next   = 1'b0;
`endif
        end else if (out_valid && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
            result    <= result_next;
            result_hi <= result_hi_next;
            zero      <= zero_next;
            ovf       <= ovf_next;
            illegal   <= illegal_next;
        end
    end

endmodule

// File: tb/tb_pipeline_ex_mdu.sv
// Scoreboard bench for pipeline_ex_mdu: random and directed ops against an arithmetic model.
module tb_pipeline_ex_mdu;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         flush;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         ovf;
    logic         illegal;

    pipeline_ex_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         ill;
        int           lat;
        int           due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rdy_force = 1'b1;
    bit   rdy_val = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endfunction

    // Reference: results derived from the arithmetic meaning of each opcode
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] wide;
`ifdef EX_MDU_EN
        logic [2*W-1:0] prod;
`endif
        e.res = '0; e.hi = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 0; e.due = 0;
        case (o)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                wide = {a[W-1], a} + {b[W-1], b};
                e.res = wide[W-1:0];
                e.ovf = wide[W] ^ wide[W-1];
            end
            4'b0110: begin
                wide = {a[W-1], a} - {b[W-1], b};
                e.res = wide[W-1:0];
                e.ovf = wide[W] ^ wide[W-1];
            end
            4'b0111: e.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: e.res = b << 16;
`ifdef EX_MDU_EN
            4'b1000: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = prod[W-1:0];
                e.hi  = prod[2*W-1:W];
                e.lat = W;
            end
            4'b1001: begin
                if (b == '0) begin
                    e.res = '1;
                    e.hi  = a;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
                e.lat = W;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Monitor: latency on first presentation, value on consume, stability while stalled
    bit           head_seen = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_flush = 1'b0;
    logic [W-1:0] prev_res, prev_hi;
    logic [2:0]   prev_flags;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            head_seen  = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_stall && !prev_flush) begin
                tests++;
                if (!(out_valid && result == prev_res && result_hi == prev_hi &&
                      {zero, ovf, illegal} == prev_flags)) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b res=%h hi=%h, expected v=1 res=%h hi=%h",
                             out_valid, result, result_hi, prev_res, prev_hi);
                end
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    if (out_ready) check(1'b0, "unexpected_out", 64'(result), 64'(0));
                end else begin
                    if (!head_seen) begin
                        check(cyc == q[0].due, "latency", 64'(cyc), 64'(q[0].due));
                        head_seen = 1'b1;
                    end
                    if (out_ready) begin
                        tests++;
                        if (result !== q[0].res || result_hi !== q[0].hi || zero !== q[0].zero ||
                            ovf !== q[0].ovf || illegal !== q[0].ill) begin
                            fails++;
                            $display("FAIL result: got res=%h hi=%h z=%b o=%b i=%b, expected res=%h hi=%h z=%b o=%b i=%b",
                                     result, result_hi, zero, ovf, illegal,
                                     q[0].res, q[0].hi, q[0].zero, q[0].ovf, q[0].ill);
                        end else begin
                            $display("[TB] ok res=%h hi=%h z=%b o=%b i=%b", result, result_hi, zero, ovf, illegal);
                        end
                        void'(q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            prev_hi    = result_hi;
            prev_flags = {zero, ovf, illegal};
            prev_flush = flush;
            if (flush) begin
                q.delete();
                head_seen = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        in_valid = 1'b1; op = o; srca = a; srcb = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check(1'b0, "accept_timeout", 64'(n), 64'(0));
        end else begin
            e = model(o, a, b);
            e.due = cyc + 1 + e.lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op   = 4'($urandom);
        srca = W'($urandom);
        srcb = W'($urandom);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        check(q.size() == 0, "drain", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; in_valid = 1'b0; op = '0; srca = '0; srcb = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'(0));
        check(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'(0));
        check(result == '0, "rst_result", 64'(result), 64'(0));
        check(result_hi == '0, "rst_result_hi", 64'(result_hi), 64'(0));
        check(zero == 1'b1, "rst_zero", 64'(zero), 64'(1));
        check(ovf == 1'b0, "rst_ovf", 64'(ovf), 64'(0));
        check(illegal == 1'b0, "rst_illegal", 64'(illegal), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "in_ready_after_reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Signed overflow boundary, then MULU (legal or illegal depending on build)
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001);
        issue(4'b1000, 32'd3, 32'd4);
`ifdef EX_MDU_EN
        drain();
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < W - 1; i++) begin
            @(negedge clk);
            check(in_ready == 1'b0, "busy_in_ready", 64'(in_ready), 64'(0));
        end
        issue(4'b1001, 32'd100, 32'd7);
        issue(4'b1001, 32'd5, 32'd0);
`endif
        drain();

        // Three ORs with the consumer stalled for three cycles
        rdy_val = 1'b0;
        issue(4'b0001, 32'h1234_0000, 32'h0000_5678);
        fork
            begin
                issue(4'b0001, 32'hA000_0000, 32'h0000_000B);
                issue(4'b0001, 32'h0F0F_0000, 32'h0000_F0F0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'(0));
                end
                @(posedge clk);
                #1;
                rdy_val = 1'b1;
            end
        join
        drain();

        // Flush discards pending/in-flight work
`ifdef EX_MDU_EN
        issue(4'b1001, 32'd1000, 32'd3);
        repeat (8) @(posedge clk);
        #1;
        do_flush();
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "flush_out_valid", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
`else
        rdy_val = 1'b0;
        issue(4'b0010, 32'd1, 32'd1);
        do_flush();
        @(negedge clk);
        check(out_valid == 1'b0, "flush_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
`endif
        issue(4'b0010, 32'd2, 32'd3);
        drain();

        // Random traffic with random backpressure
        rdy_force = 1'b0;
        for (int i = 0; i < 250; i++) begin
            issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
        end
        rdy_force = 1'b1;
        rdy_val = 1'b1;
        drain();

        // Reset mid-stream: out_valid clears at once and nothing emerges afterwards
        rdy_val = 1'b0;
`ifdef EX_MDU_EN
        issue(4'b1000, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
`else
        issue(4'b0001, 32'd7, 32'd9);
`endif
        #1;
        reset = 1'b0;
        #1;
        check(out_valid == 1'b0, "reset_mid_out_valid", 64'(out_valid), 64'(0));
        check(in_ready == 1'b0, "reset_mid_in_ready", 64'(in_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rdy_val = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "after_reset_no_result", 64'(out_valid), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
